// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and helpers for the decode-stage register file with
// in-flight write scoreboard.
package regfile_scoreboard_pkg;

  localparam int REGFILE_DSIZE        = 16;
  localparam int REGFILE_ASIZE        = 4;
  localparam int REGFILE_NREAD        = 2;
  localparam int REGFILE_MAX_INFLIGHT = 3;

  // Bits needed to hold 0..max_inflight pending writes
  function automatic int cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating up/down with clear and a
// flag for a decrement attempted at zero.
module sb_counter #(
  parameter int CW  = 2,
  parameter int MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          underflow
);

  localparam logic [CW-1:0] CMAX = CW'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CMAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Simultaneous inc/dec nets out, so it cannot underflow
  assign underflow = dec & ~inc & ~clr & (cnt == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: combinational read ports with WB bypass,
// optional hardwired zero register and RAW-hazard scoreboard driving stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DSIZE        = REGFILE_DSIZE,
  parameter int ASIZE        = REGFILE_ASIZE,
  parameter int NREAD        = REGFILE_NREAD,
  parameter int MAX_INFLIGHT = REGFILE_MAX_INFLIGHT,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*ASIZE-1:0] raddr,
  input  logic [NREAD-1:0]       rused,
  output logic [NREAD*DSIZE-1:0] rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic [ASIZE-1:0]       issue_waddr,
  output logic                   stall,
  input  logic                   wen,
  input  logic [ASIZE-1:0]       waddr,
  input  logic [DSIZE-1:0]       wdata,
  input  logic                   flush,
  output logic                   sb_err
);

  localparam int DEPTH = 2 ** ASIZE;
  localparam int CW    = cnt_width(MAX_INFLIGHT);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  logic [DSIZE-1:0] regs [DEPTH];
  logic [CW-1:0]    cnt  [DEPTH];
  logic [DEPTH-1:0] inc_vec;
  logic [DEPTH-1:0] dec_vec;
  logic [DEPTH-1:0] uf_vec;
  logic             retire;
  logic             issue_fire;

  assign retire     = wen & ~(ZR & (waddr == '0));
  assign issue_fire = issue_valid & ~stall & issue_wen & ~(ZR & (issue_waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else if (retire) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_sb
    assign inc_vec[g] = issue_fire & (issue_waddr == ASIZE'(g));
    assign dec_vec[g] = retire & (waddr == ASIZE'(g));

    sb_counter #(
      .CW  (CW),
      .MAX (MAX_INFLIGHT)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .inc       (inc_vec[g]),
      .dec       (dec_vec[g]),
      .cnt       (cnt[g]),
      .underflow (uf_vec[g])
    );
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ASIZE-1:0] ra;
    logic             ra_zero;
    logic             wb_hit;

    assign ra      = raddr[i*ASIZE +: ASIZE];
    assign ra_zero = ZR & (ra == '0);
    assign wb_hit  = BP & wen & (waddr == ra);

    assign rdata[i*DSIZE +: DSIZE] = ra_zero ? '0 : (wb_hit ? wdata : regs[ra]);

    // The last outstanding write landing this cycle already resolves the hazard
    assign rbusy[i] = ~ra_zero & (cnt[ra] != '0)
                    & ~(BP & retire & (waddr == ra) & (cnt[ra] == CONE));
  end

  assign stall = issue_valid &
                 ( (|(rbusy & rused)) |
                   (issue_wen & (cnt[issue_waddr] == CMAX) &
                    ~(retire & (waddr == issue_waddr))) );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sb_err <= 1'b0;
    else if (|uf_vec) sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations queued when a step is
// driven and compared in order when the DUT output is sampled.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  raddr;
  logic [1:0]  rused;
  logic [31:0] rdata;
  logic [31:0] rdata_nb;
  logic [1:0]  rbusy;
  logic [1:0]  rbusy_nb;
  logic        issue_valid, issue_wen;
  logic [3:0]  issue_waddr;
  logic        stall, stall_nb;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        flush;
  logic        sb_err, sb_err_nb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rused(rused), .rdata(rdata),
    .rbusy(rbusy), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .stall(stall), .wen(wen), .waddr(waddr),
    .wdata(wdata), .flush(flush), .sb_err(sb_err)
  );

  regfile_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rused(rused), .rdata(rdata_nb),
    .rbusy(rbusy_nb), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .stall(stall_nb), .wen(wen), .waddr(waddr),
    .wdata(wdata), .flush(flush), .sb_err(sb_err_nb)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic iw, input logic [3:0] ia,
                       input logic [3:0] r0, input logic [3:0] r1, input logic [1:0] ru,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic fl);
    @(negedge clk);
    issue_valid = iv; issue_wen = iw; issue_waddr = ia;
    raddr = {r1, r0}; rused = ru;
    wen = we; waddr = wa; wdata = wd; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    raddr = '0; rused = '0; issue_valid = 0; issue_wen = 0; issue_waddr = '0;
    wen = 0; waddr = '0; wdata = '0; flush = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    drive(0,0,0, 5,0,2'b00, 0,0,16'h0, 0);
    expect_val("rst_rdata_r5", 32'h0); expect_val("rst_stall", 32'h0);
    expect_val("rst_rbusy", 32'h0);    expect_val("rst_sb_err", 32'h0);
    #1 observe(rdata[15:0]); observe(stall); observe(rbusy); observe(sb_err);

    // unscheduled write to r5, then async reset mid-run
    drive(0,0,0, 5,0,2'b00, 1,5,16'h5555, 0);
    expect_val("bypass_r5", 32'h5555);
    #1 observe(rdata[15:0]);
    drive(0,0,0, 5,0,2'b00, 0,0,16'h0, 0);
    expect_val("read_r5", 32'h5555); expect_val("sb_err_orphan_wb", 32'h1);
    #1 observe(rdata[15:0]); observe(sb_err);
    @(negedge clk); rst = 1'b1;
    expect_val("midrst_rdata", 32'h0); expect_val("midrst_sb_err", 32'h0);
    expect_val("midrst_rdata_nb", 32'h0);
    #1 observe(rdata[15:0]); observe(sb_err); observe(rdata_nb[15:0]);
    @(negedge clk); rst = 1'b0;

    // write-through bypass vs no-bypass
    drive(1,1,3, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("issue_r3_stall", 32'h0);
    #1 observe(stall);
    drive(0,0,0, 3,0,2'b01, 1,3,16'hBEEF, 0);
    expect_val("bypass_rdata", 32'hBEEF); expect_val("nobypass_rdata_old", 32'h0);
    expect_val("bypass_rbusy", 32'h0);    expect_val("nobypass_rbusy", 32'h1);
    #1 observe(rdata[15:0]); observe(rdata_nb[15:0]); observe(rbusy[0]); observe(rbusy_nb[0]);
    drive(0,0,0, 3,0,2'b01, 0,0,16'h0, 0);
    expect_val("nobypass_rdata_next", 32'hBEEF); expect_val("r3_rbusy_after", 32'h0);
    expect_val("sb_err_after_r3", 32'h0);
    #1 observe(rdata_nb[15:0]); observe(rbusy[0]); observe(sb_err);

    // zero register
    drive(1,1,0, 0,0,2'b01, 1,0,16'h1234, 0);
    expect_val("r0_bypass_rdata", 32'h0); expect_val("r0_stall", 32'h0);
    expect_val("r0_rbusy", 32'h0);
    #1 observe(rdata[15:0]); observe(stall); observe(rbusy[0]);
    drive(1,0,0, 0,0,2'b01, 0,0,16'h0, 0);
    expect_val("r0_rdata", 32'h0); expect_val("r0_rdata_nb", 32'h0);
    expect_val("r0_stall_next", 32'h0); expect_val("r0_no_sb_err", 32'h0);
    #1 observe(rdata[15:0]); observe(rdata_nb[15:0]); observe(stall); observe(sb_err);

    // RAW hazard on r4
    drive(1,1,4, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("issue_r4_stall", 32'h0);
    #1 observe(stall);
    drive(1,0,0, 4,0,2'b01, 0,0,16'h0, 0);
    expect_val("raw_p0_stall", 32'h1); expect_val("raw_p0_rbusy", 32'h1);
    #1 observe(stall); observe(rbusy[0]);
    drive(1,0,0, 0,4,2'b10, 0,0,16'h0, 0);
    expect_val("raw_p1_stall", 32'h1); expect_val("raw_p1_rbusy", 32'h2);
    #1 observe(stall); observe(rbusy);
    drive(1,0,0, 4,0,2'b01, 1,4,16'h4444, 0);
    expect_val("raw_wb_stall", 32'h0); expect_val("raw_wb_rdata", 32'h4444);
    #1 observe(stall); observe(rdata[15:0]);
    drive(1,1,4, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("reissue_r4_stall", 32'h0);
    #1 observe(stall);
    drive(1,0,0, 4,0,2'b00, 0,0,16'h0, 0);
    expect_val("unused_stall", 32'h0); expect_val("unused_rbusy", 32'h1);
    #1 observe(stall); observe(rbusy[0]);
    drive(0,0,0, 0,0,2'b00, 1,4,16'h4545, 0);

    // saturation on r7
    drive(1,1,7, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("sat_i1_stall", 32'h0); expect_val("sb_err_after_r4", 32'h0);
    #1 observe(stall); observe(sb_err);
    drive(1,1,7, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("sat_i2_stall", 32'h0);
    #1 observe(stall);
    drive(1,1,7, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("sat_i3_stall", 32'h0);
    #1 observe(stall);
    drive(1,1,7, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("sat_i4_stall", 32'h1);
    #1 observe(stall);
    drive(1,1,7, 0,0,2'b00, 1,7,16'h7777, 0);
    expect_val("sat_i4_retire_stall", 32'h0);
    #1 observe(stall);
    drive(1,1,7, 0,0,2'b00, 0,0,16'h0, 0);
    expect_val("sat_still_full", 32'h1);
    #1 observe(stall);
    drive(0,0,0, 7,0,2'b00, 1,7,16'h7001, 0);
    expect_val("drain3_rbusy", 32'h1);
    #1 observe(rbusy[0]);
    drive(0,0,0, 7,0,2'b00, 1,7,16'h7002, 0);
    expect_val("drain2_rbusy", 32'h1);
    #1 observe(rbusy[0]);
    drive(0,0,0, 7,0,2'b00, 1,7,16'h7003, 0);
    expect_val("drain1_rbusy_resolve", 32'h0); expect_val("drain1_rbusy_nb", 32'h1);
    #1 observe(rbusy[0]); observe(rbusy_nb[0]);
    drive(0,0,0, 7,0,2'b00, 0,0,16'h0, 0);
    expect_val("drained_rbusy", 32'h0); expect_val("drained_sb_err", 32'h0);
    expect_val("drained_rdata", 32'h7003);
    #1 observe(rbusy[0]); observe(sb_err); observe(rdata[15:0]);

    // flush and underflow
    drive(1,1,2, 0,0,2'b00, 0,0,16'h0, 0);
    drive(1,1,2, 0,0,2'b00, 0,0,16'h0, 0);
    drive(0,0,0, 2,0,2'b00, 1,9,16'h9999, 1);
    expect_val("preflush_rbusy", 32'h1);
    #1 observe(rbusy[0]);
    drive(0,0,0, 2,9,2'b00, 0,0,16'h0, 0);
    expect_val("postflush_rbusy", 32'h0); expect_val("flush_write_r9", 32'h9999);
    expect_val("flush_no_sb_err", 32'h0);
    #1 observe(rbusy[0]); observe(rdata[31:16]); observe(sb_err);
    drive(0,0,0, 2,0,2'b00, 1,2,16'h2222, 0);
    drive(0,0,0, 2,0,2'b00, 0,0,16'h0, 0);
    expect_val("underflow_sb_err", 32'h1); expect_val("underflow_write_r2", 32'h2222);
    #1 observe(sb_err); observe(rdata[15:0]);
    repeat (3) @(negedge clk);
    expect_val("sb_err_sticky", 32'h1);
    #1 observe(sb_err);
    @(negedge clk); rst = 1'b1;
    expect_val("final_rst_sb_err", 32'h0); expect_val("final_rst_rdata", 32'h0);
    #1 observe(sb_err); observe(rdata[15:0]);
    @(negedge clk); rst = 1'b0;

    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
